// File: rtl/rv_pkg.sv
// Shared RV32I encoding definitions: instruction formats, major opcodes and the canonical NOP.
// Used by instr_pack and instr_encoder.
package rv_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [31:0] NOP = 32'h00000013;

  // True when imm[31:msb] is a pure sign extension (all zeros or all ones).
  function automatic logic sext_fits(input logic [31:0] imm, input int msb);
    logic signed [31:0] s;
    s = $signed(imm) >>> msb;
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer: scatters register, funct and immediate fields into one word.
// Optional immediate range checking is enabled by defining IMM_RANGE_CHECK_EN.
module instr_pack
  import rv_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP
) (
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        illegal,
  output logic        range_err
);

  always_comb begin
    instr     = NOP_WORD;
    illegal   = 1'b0;
    range_err = 1'b0;
    case (fmt)
      FMT_R: instr = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: instr = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: instr = {imm[31:12], rd, opcode};
      FMT_J: instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: illegal = 1'b1;
    endcase
`ifdef IMM_RANGE_CHECK_EN
    // Branch/jump offsets must be halfword aligned; bit 0 is never encoded.
    case (fmt)
      FMT_I, FMT_S: range_err = !sext_fits(imm, 11);
      FMT_B:        range_err = !sext_fits(imm, 12) || imm[0];
      FMT_J:        range_err = !sext_fits(imm, 20) || imm[0];
      FMT_U:        range_err = |imm[11:0];
      default:      range_err = 1'b0;
    endcase
`endif
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: one registered stage with valid/ready, running word address,
// saturating accept count and sticky error. Define IMM_RANGE_CHECK_EN to flag out-of-range immediates.
module instr_encoder
  import rv_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int          BASE_ADDR = 0,
  parameter logic [31:0] NOP_WORD  = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              in_restart,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [15:0]       count
);

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [31:0]       instr_p0;
  logic              illegal_p0;
  logic              range_err_p0;
  logic              acc_p0;
  logic [ADDR_W-1:0] addr_p0;

  logic              vld_p1;
  logic [31:0]       instr_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [ADDR_W-1:0] next_addr;
  logic              err_q;
  logic [15:0]       count_q;

  // ---- stage 0: field packing and accept decision
  instr_pack #(
    .NOP_WORD (NOP_WORD)
  ) u_pack (
    .fmt       (in_fmt),
    .opcode    (in_opcode),
    .rd        (in_rd),
    .rs1       (in_rs1),
    .rs2       (in_rs2),
    .funct3    (in_funct3),
    .funct7    (in_funct7),
    .imm       (in_imm),
    .instr     (instr_p0),
    .illegal   (illegal_p0),
    .range_err (range_err_p0)
  );

  assign in_ready = !vld_p1 || out_ready;
  assign acc_p0   = in_valid && in_ready;
  assign addr_p0  = in_restart ? BASE_A : next_addr;

  // ---- stage 1: output register, address counter, count and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      instr_p1  <= '0;
      addr_p1   <= BASE_A;
      next_addr <= BASE_A;
      err_q     <= 1'b0;
      count_q   <= '0;
    end else if (acc_p0) begin
      vld_p1    <= 1'b1;
      instr_p1  <= instr_p0;
      addr_p1   <= addr_p0;
      next_addr <= addr_p0 + ADDR_W'(1);
      count_q   <= sat_inc(count_q);
      if (illegal_p0 || range_err_p0) err_q <= 1'b1;
    end else begin
      // A stalled word keeps its address; restart only retargets the counter.
      if (out_ready) vld_p1 <= 1'b0;
      if (in_restart) next_addr <= BASE_A;
    end
  end

  assign out_valid = vld_p1;
  assign out_instr = instr_p1;
  assign out_addr  = addr_p1;
  assign out_err   = err_q;
  assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors plus random traffic against a field-level
// reference model. A second instance with ADDR_W=2 exercises address wrap.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_restart, out_ready;
  logic [2:0]  in_fmt, in_funct3;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;

  logic        in_ready, out_valid, out_err;
  logic [31:0] out_instr;
  logic [9:0]  out_addr;
  logic [15:0] count;
  logic        in_ready_w2, out_valid_w2, out_err_w2;
  logic [31:0] out_instr_w2;
  logic [1:0]  out_addr_w2;
  logic [15:0] count_w2;

  int checks = 0;
  int errors = 0;

  bit          mvld;
  logic [31:0] minstr;
  int          maddr, mnext, mcount;
  bit          merr;

  always #5 clk = ~clk;

  instr_encoder u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_restart(in_restart),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .out_err(out_err), .count(count)
  );

  instr_encoder #(.ADDR_W(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w2), .in_fmt(in_fmt),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_restart(in_restart),
    .out_valid(out_valid_w2), .out_ready(out_ready), .out_instr(out_instr_w2),
    .out_addr(out_addr_w2), .out_err(out_err_w2), .count(count_w2)
  );

  // Reference encoding built by shifting each field to its documented bit position.
  function automatic logic [31:0] ref_word(input logic [2:0] f, input logic [6:0] op,
                                           input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [31:0] imm,
                                           output bit bad);
    logic [31:0] base;
    int si;
    base = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    si   = $signed(imm);
    bad  = 1'b0;
    ref_word = 32'h00000013;
    case (f)
      3'd0: ref_word = base | (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rd) << 7);
      3'd1: ref_word = base | ((imm & 32'hFFF) << 20) | (32'(rd) << 7);
      3'd2: ref_word = base | (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20)
                            | ((imm & 32'h1F) << 7);
      3'd3: ref_word = base | (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                            | (32'(rs2) << 20) | (((imm >> 1) & 32'hF) << 8)
                            | (((imm >> 11) & 1) << 7);
      3'd4: ref_word = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
      3'd5: ref_word = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                     | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                     | (32'(rd) << 7) | 32'(op);
      default: bad = 1'b1;
    endcase
`ifdef IMM_RANGE_CHECK_EN
    case (f)
      3'd1, 3'd2: if (si < -2048 || si > 2047) bad = 1'b1;
      3'd3: if (si < -4096 || si > 4095 || imm[0]) bad = 1'b1;
      3'd5: if (si < -(1 << 20) || si > (1 << 20) - 1 || imm[0]) bad = 1'b1;
      3'd4: if ((imm % 4096) != 0) bad = 1'b1;
      default: ;
    endcase
`else
    if (si == 0) bad = bad;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mvld = 0; minstr = '0; maddr = 0; mnext = 0; mcount = 0; merr = 0;
  endtask

  task automatic check_outputs();
    chk("out_valid", out_valid, mvld);
    chk("out_instr", out_instr, minstr);
    chk("out_addr", out_addr, maddr % 1024);
    chk("out_err", out_err, merr);
    chk("count", count, mcount);
    chk("w2_out_valid", out_valid_w2, mvld);
    chk("w2_out_instr", out_instr_w2, minstr);
    chk("w2_out_addr", out_addr_w2, maddr % 4);
    chk("w2_out_err", out_err_w2, merr);
    chk("w2_count", count_w2, mcount);
  endtask

  // One clock: check ready, predict the edge, then compare all outputs just after it.
  task automatic step();
    bit          acc, bad;
    logic [31:0] w;
    int          a;
    #1;
    chk("in_ready", in_ready, !mvld || out_ready);
    chk("w2_in_ready", in_ready_w2, !mvld || out_ready);
    acc = in_valid && (!mvld || out_ready);
    w = ref_word(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, bad);
    @(posedge clk);
    if (acc) begin
      a      = in_restart ? 0 : mnext;
      mvld   = 1;
      minstr = w;
      maddr  = a;
      mnext  = a + 1;
      if (mcount < 65535) mcount++;
      if (bad) merr = 1;
    end else begin
      if (out_ready) mvld = 0;
      if (in_restart) mnext = 0;
    end
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [31:0] imm);
    in_valid = 1; in_restart = 0; in_fmt = f; in_opcode = op; in_rd = rd;
    in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3; in_funct7 = 7'd0; in_imm = imm;
  endtask

  initial begin
    int r;
    rst = 1; in_valid = 0; in_restart = 0; out_ready = 1; in_fmt = 0; in_opcode = 0;
    in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_funct3 = 0; in_funct7 = 0; in_imm = 0;
    model_reset();
    #2;
    check_outputs();
    @(posedge clk); #1;
    rst = 0;

    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    step();
    chk("addi_word", out_instr, 32'h00500093);
    chk("addi_addr", out_addr, 32'd0);
    chk("addi_count", count, 32'd1);

    drive(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8);
    step();
    chk("sw_word", out_instr, 32'h0020A423);
    chk("sw_addr", out_addr, 32'd1);
    drive(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFC);
    step();
    chk("beq_word", out_instr, 32'hFE000EE3);
    chk("beq_addr", out_addr, 32'd2);
    drive(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd8);
    step();
    chk("jal_word", out_instr, 32'h008000EF);
    chk("jal_addr", out_addr, 32'd3);
    drive(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000);
    step();
    chk("lui_word", out_instr, 32'h123452B7);
    chk("lui_addr", out_addr, 32'd4);
    chk("w2_wrap_addr", out_addr_w2, 32'd0);

    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    in_restart = 1;
    step();
    chk("restart_addr", out_addr, 32'd0);
    chk("w2_restart_addr", out_addr_w2, 32'd0);

    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
    step();
    chk("addi2048_word", out_instr, 32'h80000093);
    chk("after_restart_addr", out_addr, 32'd1);
`ifdef IMM_RANGE_CHECK_EN
    chk("addi2048_err", out_err, 32'd1);
`else
    chk("addi2048_err", out_err, 32'd0);
`endif

    in_valid = 0; out_ready = 1;
    step();
    drive(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 32'd7);
    out_ready = 0;
    step();
    drive(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8);
    repeat (3) begin
      step();
      chk("stall_in_ready", in_ready, 32'd0);
      chk("stall_word", out_instr, 32'h00700193);
    end
    out_ready = 1;
    step();
    chk("post_stall_word", out_instr, 32'h0020A423);
    in_valid = 0;
    step();

    drive(3'd7, 7'h33, 5'd4, 5'd4, 5'd4, 3'd1, 32'd0);
    step();
    chk("illegal_word", out_instr, 32'h00000013);
    chk("illegal_err", out_err, 32'd1);
    drive(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 32'd0);
    step();
    chk("err_sticky", out_err, 32'd1);

    out_ready = 0;
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
    step();
    rst = 1;
    #1;
    model_reset();
    check_outputs();
    #1;
    rst = 0;

    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      in_restart = ($urandom_range(0, 15) == 0);
      in_fmt     = 3'($urandom_range(0, 7));
      in_opcode  = 7'($urandom);
      in_rd      = 5'($urandom);
      in_rs1     = 5'($urandom);
      in_rs2     = 5'($urandom);
      in_funct3  = 3'($urandom);
      in_funct7  = 7'($urandom);
      r          = $urandom_range(0, 8191) - 4096;
      in_imm     = $urandom_range(0, 1) ? $urandom : 32'(r);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the decode-side immediate generator: packs format, register, funct and 32-bit immediate fields into one RV32I instruction word.
- Feeds the instruction-memory loader and the test-program builder, driving imem write data and address.
- Single-stage registered pipeline with valid/ready on both sides.
- Keeps a running write address so consecutive accepted instructions land in consecutive words.

Parameters:
- ADDR_W, 10, width of the word address counter.
- BASE_ADDR, 0, word address loaded at reset and on in_restart.
- NOP_WORD, 32'h00000013, word emitted for an illegal format (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder can accept this cycle.
- in_fmt  in  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- in_opcode  in  7  opcode, copied to bits 6:0.
- in_rd  in  5  destination register.
- in_rs1  in  5  first source register.
- in_rs2  in  5  second source register.
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7 (R only).
- in_imm  in  32  byte-offset / value immediate, in the same form the decode side produces.
- in_restart  in  1  reload address counter to BASE_ADDR.
- out_valid  out  1  out_instr/out_addr valid.
- out_ready  in  1  consumer accepts.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  word address for out_instr.
- out_err  out  1  sticky: illegal format seen (plus range errors when the option is enabled).
- count  out  16  number of instructions accepted, saturating.

Behaviour:
- Reset (async, immediate): out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_err=0, count=0; the internal next-address counter is also set to BASE_ADDR.
- in_ready = !out_valid || out_ready (combinational).
- Accept occurs when in_valid && in_ready. On the next edge:
  - out_instr is loaded with the packed word and out_valid=1.
  - out_addr is loaded with the next-address counter, and the counter increments.
  - Latency is 1 cycle. Back-to-back throughput is 1 per cycle while out_ready=1.
- Output consumed with no new accept: out_valid=0 on the next edge; out_instr and out_addr hold.
- Stall (out_valid && !out_ready): all outputs hold, and in_ready=0.
- Packing, with opcode in bits 6:0 for every format:
  - R: {funct7, rs2, rs1, funct3, rd}
  - I: {imm[11:0], rs1, funct3, rd}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0]}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11]}
  - U: {imm[31:12], rd}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd}
  - Unused immediate bits are ignored.
- Illegal format (in_fmt 6 or 7): emit NOP_WORD and set out_err. The word still consumes an address.
- Address counter: wraps modulo 2^ADDR_W, with no flag.
- in_restart:
  - Alone: the counter reloads to BASE_ADDR on the next edge.
  - Together with an accept: the accepted word takes BASE_ADDR and the counter becomes BASE_ADDR+1.
  - in_restart does not alter out_addr of a pending (stalled) word.
- count: increments per accept and saturates at 16'hFFFF.
- out_err: clears only on rst.
- Reset mid-stall: the pending word is dropped and out_valid=0.

Optional Feature:
- Macro: IMM_RANGE_CHECK_EN.
- Defined: an immediate that does not fit its format sets out_err. The word is still emitted, packed from truncated bits. Fit rules:
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
- Undefined: no range logic; out_err reflects illegal formats only.

Decomposition:
- Shared package rv_pkg holds:
  - format enum (FMT_R..FMT_J);
  - opcode constants (OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_REG);
  - NOP constant.
- One combinational sub-module, instr_pack: fields in, word and range-error out.
- instr_encoder adds the handshake register, address counter, count and sticky error.

Test Plan:
- addi x1,x0,5 (fmt I, op 0010011, f3 0, imm 5), out_ready=1 → next cycle out_instr=0x00500093, out_addr=0, count=1.
- Back-to-back, out_ready=1:
  - sw x2,8(x1) → 0x0020A423, addr 1.
  - beq x0,x0,-4 → 0xFE000EE3, addr 2.
  - jal x1,8 → 0x008000EF, addr 3.
  - lui x5,0x12345000 → 0x123452B7, addr 4.
- Stall: hold out_ready=0 for 3 cycles after one accept → in_ready=0, out_instr/out_addr stable, a second in_valid is not taken; release → second word appears on the following cycle.
- in_fmt=7 → out_instr=0x00000013 and out_err=1, staying 1 over later legal words until rst.
- With IMM_RANGE_CHECK_EN: addi imm=2048 → out_err=1, out_instr=0x80000093. Without it: same word, out_err=0.
- Set ADDR_W=2 and issue 5 accepts → addresses 0,1,2,3,0. in_restart together with the 6th accept → addr 0, then 1. Assert rst during a stall → out_valid drops immediately and out_addr=0.
